// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
// Converts whole-line (256-bit) requests from the L2 cache into 4-beat,
// 64-bit burst transactions toward main memory. It returns the assembled
// line and a one-cycle completion pulse to the cache.
//
// Ports
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   line_i     : 256-bit write line from the cache
//   line_o     : 256-bit read line to the cache (the line buffer, always visible)
//   address_i  : line address from the cache
//   read_i     : cache line-read request, held until resp_o
//   write_i    : cache line-write request, held until resp_o
//   resp_o     : one-cycle completion pulse to the cache
//   burst_i    : 64-bit read beat from memory
//   burst_o    : 64-bit write beat to memory
//   address_o  : line-aligned burst address to memory
//   read_o     : memory burst-read request
//   write_o    : memory burst-write request
//   resp_i     : memory beat strobe, one beat per cycle it is high

module l2_cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [1:0]     r_cnt;
    logic [255:0]   r_lineBuf;
    logic [31:0]    r_addrQ;
    logic           w_lastBeat;

    // A beat on the fourth slot ends the burst; the 2-bit counter wraps to
    // zero on that same edge, so it never counts past four beats.
    assign w_lastBeat = resp_i && (r_cnt == 2'd3);

    // State register. Reset drops read_o/write_o immediately because they
    // are decoded straight from this register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode. A pending write wins over a read so a dirty
    // eviction leaves before the refill; the read is simply re-sampled the
    // next time we are back in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_nextState = WR;
                end else if (read_i) begin
                    w_nextState = RD;
                end
            end
            RD: begin
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            WR: begin
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch the aligned address and (for writes) the line on
    // acceptance, fill the buffer beat by beat on reads, and advance the
    // beat counter on every memory strobe. Inputs are only looked at in
    // IDLE, so the cache may change them freely once a burst is under way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_lineBuf <= '0;
            r_addrQ   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_addrQ   <= {address_i[31:5], 5'b0};
                        r_lineBuf <= line_i;
                        r_cnt     <= 2'd0;
                    end else if (read_i) begin
                        r_addrQ <= {address_i[31:5], 5'b0};
                        r_cnt   <= 2'd0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        r_lineBuf[{r_cnt, 6'b0} +: 64] <= burst_i;
                        r_cnt                          <= r_cnt + 2'd1;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs: every memory- and cache-facing strobe comes from
    // registered state only, so there is no input-to-output path. burst_o
    // is zero outside a write burst so idle memory sees a quiet bus.
    always_comb begin
        read_o    = (r_state == RD);
        write_o   = (r_state == WR);
        resp_o    = (r_state == DONE);
        address_o = r_addrQ;
        line_o    = r_lineBuf;
        burst_o   = '0;
        if (r_state == WR) begin
            burst_o = r_lineBuf[{r_cnt, 6'b0} +: 64];
        end
    end

endmodule

// File: doc/l2_cacheline_adaptor.md
# l2_cacheline_adaptor

Responder for the L2 cache's 256-bit physical-memory port. Accepts a whole-line read or write from the L2 datapath/control and converts it to a 4-beat, 64-bit burst transaction toward main memory. Returns the assembled line and a one-cycle completion pulse to the cache. Sits between the L2 cache and the physical memory model/controller.

## Interface
- s_line, 256, line width in bits (cache side)
- s_burst, 64, beat width in bits (memory side); beats = s_line/s_burst = 4
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- line_i  in  256  write line from cache (pmem_wdata)
- line_o  out  256  read line to cache (pmem_rdata)
- address_i  in  32  line address from cache (pmem_address)
- read_i  in  1  cache line-read request, held until resp_o
- write_i  in  1  cache line-write request, held until resp_o
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  64  read beat from memory
- burst_o  out  64  write beat to memory
- address_o  out  32  burst address to memory
- read_o  out  1  memory burst-read request
- write_o  out  1  memory burst-write request
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high

## Operation
- States: IDLE, RD, WR, DONE. Registered state, 2-bit beat counter cnt, 256-bit line buffer buf, 32-bit address register addr_q.
- IDLE: if write_i=1 -> latch addr_q={address_i[31:5],5'b0}, buf=line_i, cnt=0, go WR. Else if read_i=1 -> latch addr_q, cnt=0, go RD. write_i has priority when both high (dirty eviction first); read is not latched and must be re-presented.
- RD: read_o=1. On each cycle with resp_i=1: buf[64*cnt +: 64]=burst_i, cnt++. On the beat with cnt=3 -> go DONE. resp_i=0 cycles are wait states (gaps allowed).
- WR: write_o=1, burst_o=buf[64*cnt +: 64]. On each resp_i=1: cnt++. On resp_i with cnt=3 -> go DONE.
- DONE: resp_o=1 for exactly one cycle, line_o=buf; unconditionally go IDLE.
- Beat order little-endian: beat 0 = bits [63:0], beat 3 = bits [255:192].
- address_o=addr_q in all states; constant for the whole burst; low 5 bits always 0.
- line_o = buf continuously; holds last completed read (or last written line after a write) until overwritten.
- read_o/write_o/burst_o/resp_o are decoded from registered state (Moore); no combinational path from any input to any output.
- resp_i in IDLE or DONE ignored. Changes on read_i/write_i/address_i/line_i after acceptance ignored until return to IDLE.
- Counter wraps 3->0 on the final beat; never more than 4 beats per transaction.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, buf=0, addr_q=0; so resp_o=0, read_o=0, write_o=0, burst_o=0, address_o=0, line_o=0. Reset mid-burst aborts transaction; no resp_o is issued; memory sees read_o/write_o drop in the same cycle.
- Request sampled at edge E0; read_o/write_o high from cycle after E0.
- Read, beats on 4 consecutive cycles starting first cycle read_o high: resp_o high 5 cycles after request cycle (request cycle + 4 beat cycles, DONE in cycle 6 counting request as cycle 1). Each gap cycle adds one cycle.
- Write latency identical to read.
- Cache drops request in the cycle after resp_o (IDLE); if still held it is accepted as a new transaction.
- Back-to-back: minimum one IDLE cycle between DONE and next burst start; throughput one line per 6 cycles with no memory wait states.

## Test plan
- Read, consecutive beats 64'h0000_0000_0000_0000,...1,...2,...3, address_i=32'h1234_567F -> address_o=32'h1234_5660, read_o high 4 cycles, resp_o 1 cycle, line_o={3,2,1,0 as 64-bit words}.
- Read with gap: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o 3 cycles later than gapless case, read_o high through final beat.
- Write line_i=256'hDDDD..._CCCC..._BBBB..._AAAA... -> burst_o = AAAA..., BBBB..., CCCC..., DDDD... on successive resp_i, write_o drops after 4th, resp_o pulse once.
- read_i and write_i both high, address 32'h0000_1000 -> write burst first, resp_o, then (read_i still high) read burst accepted in next IDLE cycle.
- Assert rst after 2 read beats -> read_o=0 and all outputs 0 immediately, no resp_o; next read completes normally with all 4 beats.
- Stray resp_i pulses while IDLE and in DONE -> no state change, line_o unchanged, no extra resp_o.
